// File: rtl/cpu_pipeline_pkg.sv
// Shared encodings for the CPU pipeline control blocks.
package cpu_pipeline_pkg;
  localparam logic [4:0] REG_ZERO          = 5'd0;
  localparam logic       REG_WRITE_SRC_MEM = 1'b1;
  localparam logic [1:0] NEXT_PC_SEQ       = 2'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;
endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline-register enable/flush/bubble control: load-use stall, EX redirect
// flush and multi-cycle EX freeze with timeout, plus stall/flush counters.
module pipeline_stall_controller
  import cpu_pipeline_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           id_rs1_address,
  input  logic [4:0]           id_rs2_address,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           ex_rd_address,
  input  logic                 ex_reg_wren,
  input  logic                 ex_is_load,
  input  logic                 ex_branch_taken,
  input  logic                 ex_mc_start,
  input  logic                 ex_mc_done,
  output logic                 pc_wren,
  output logic                 if_id_wren,
  output logic                 if_id_flush,
  output logic                 id_ex_wren,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_bubble,
  output logic                 mc_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count,
  output mc_state_t            dbg_mc_state
);

  localparam int MC_CNT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [MC_CNT_W:0] MC_LIMIT = (MC_CNT_W + 1)'(MC_TIMEOUT);

  mc_state_t           mc_state, mc_state_next;
  logic [MC_CNT_W-1:0] mc_cnt, mc_cnt_next;
  logic [MC_CNT_W:0]   mc_cnt_inc;
  logic                mc_timeout_set;
  logic                timeout_hit;
  logic                mc_hold;
  logic                rs1_hit, rs2_hit, load_use;

  assign rs1_hit  = id_uses_rs1 && (id_rs1_address == ex_rd_address);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_address == ex_rd_address);
  assign load_use = (ex_is_load == REG_WRITE_SRC_MEM) && ex_reg_wren &&
                    (ex_rd_address != REG_ZERO) && (rs1_hit || rs2_hit);

  // The cycle whose increment reaches MC_TIMEOUT is the last held cycle.
  assign mc_cnt_inc  = {1'b0, mc_cnt} + (MC_CNT_W + 1)'(1);
  assign timeout_hit = (mc_cnt_inc >= MC_LIMIT);

  assign mc_hold = ((mc_state == BUSY) && !ex_mc_done) ||
                   ((mc_state == IDLE) && ex_mc_start && !ex_mc_done);

  assign dbg_mc_state = mc_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mc_state   <= IDLE;
      mc_cnt     <= '0;
      mc_timeout <= 1'b0;
    end else begin
      mc_state   <= mc_state_next;
      mc_cnt     <= mc_cnt_next;
      mc_timeout <= mc_timeout || mc_timeout_set;
    end
  end

  always_comb begin
    mc_state_next  = mc_state;
    mc_cnt_next    = mc_cnt;
    mc_timeout_set = 1'b0;
    case (mc_state)
      IDLE: begin
        if (ex_mc_start && !ex_mc_done) begin
          mc_state_next = BUSY;
          mc_cnt_next   = MC_CNT_W'(1);
        end
      end
      BUSY: begin
        if (ex_mc_done) begin
          mc_state_next = IDLE;
          mc_cnt_next   = '0;
        end else if (timeout_hit) begin
          mc_state_next  = IDLE;
          mc_cnt_next    = '0;
          mc_timeout_set = 1'b1;
        end else begin
          mc_cnt_next = mc_cnt_inc[MC_CNT_W-1:0];
        end
      end
      default: begin
        mc_state_next = IDLE;
        mc_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pc_wren       = 1'b0;
    if_id_wren    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_wren    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (!reset_n) begin
      pc_wren = 1'b0;
    end else if (mc_hold) begin
      ex_mem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is discarded, so a pending load-use is moot.
      pc_wren      = 1'b1;
      if_id_wren   = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_wren   = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      id_ex_wren   = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_wren    = 1'b1;
      if_id_wren = 1'b1;
      id_ex_wren = 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (!pc_wren),
    .count   (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (if_id_flush),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: instance a (MC_TIMEOUT=16, CNT_WIDTH=32), instance b (MC_TIMEOUT=4, CNT_WIDTH=4).
module tb_pipeline_stall_controller;
  import cpu_pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_wren, ex_is_load;
  logic       ex_branch_taken, ex_mc_start, ex_mc_done;

  logic        a_pc_wren, a_if_id_wren, a_if_id_flush, a_id_ex_wren, a_id_ex_bubble;
  logic        a_ex_mem_bubble, a_mc_timeout;
  logic [31:0] a_stall, a_flush;
  mc_state_t   a_state;
  logic        b_pc_wren, b_if_id_wren, b_if_id_flush, b_id_ex_wren, b_id_ex_bubble;
  logic        b_ex_mem_bubble, b_mc_timeout;
  logic [3:0]  b_stall, b_flush;
  mc_state_t   b_state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MC_TIMEOUT(16), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .ex_reg_wren(ex_reg_wren), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_wren(a_pc_wren), .if_id_wren(a_if_id_wren), .if_id_flush(a_if_id_flush),
    .id_ex_wren(a_id_ex_wren), .id_ex_bubble(a_id_ex_bubble), .ex_mem_bubble(a_ex_mem_bubble),
    .mc_timeout(a_mc_timeout), .stall_cycles(a_stall), .flush_count(a_flush),
    .dbg_mc_state(a_state)
  );

  pipeline_stall_controller #(.MC_TIMEOUT(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .ex_reg_wren(ex_reg_wren), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_wren(b_pc_wren), .if_id_wren(b_if_id_wren), .if_id_flush(b_if_id_flush),
    .id_ex_wren(b_id_ex_wren), .id_ex_bubble(b_id_ex_bubble), .ex_mem_bubble(b_ex_mem_bubble),
    .mc_timeout(b_mc_timeout), .stall_cycles(b_stall), .flush_count(b_flush),
    .dbg_mc_state(b_state)
  );

  // Packed view of a's controls: {pc, if_id_wren, flush, id_ex_wren, id_ex_bubble, ex_mem_bubble}
  wire [5:0] a_ctl = {a_pc_wren, a_if_id_wren, a_if_id_flush, a_id_ex_wren, a_id_ex_bubble, a_ex_mem_bubble};
  wire [5:0] b_ctl = {b_pc_wren, b_if_id_wren, b_if_id_flush, b_id_ex_wren, b_id_ex_bubble, b_ex_mem_bubble};

  localparam logic [5:0] CTL_OFF    = 6'b000000;
  localparam logic [5:0] CTL_NORMAL = 6'b110100;
  localparam logic [5:0] CTL_STALL  = 6'b000110;
  localparam logic [5:0] CTL_FLUSH  = 6'b111110;
  localparam logic [5:0] CTL_HOLD   = 6'b000001;

  task automatic set_idle();
    id_rs1_address = 5'd0; id_rs2_address = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd_address = 5'd0; ex_reg_wren = 1'b0; ex_is_load = 1'b0;
    ex_branch_taken = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
  endtask

  task automatic set_load_use();
    ex_rd_address = 5'd5; ex_is_load = 1'b1; ex_reg_wren = 1'b1;
    id_rs1_address = 5'd3; id_uses_rs1 = 1'b1;
    id_rs2_address = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_idle();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_idle();
    #1;
    n_cmp++; if (a_ctl !== CTL_OFF) begin n_fail++; $display("FAIL reset_ctl got %b want %b", a_ctl, CTL_OFF); end
    step();
    n_cmp++; if (a_state !== IDLE || a_mc_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_state got %0d/%b want 0/0", a_state, a_mc_timeout); end
    n_cmp++; if (a_stall !== 32'd0 || a_flush !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", a_stall, a_flush); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (a_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL post_reset_ctl got %b want %b", a_ctl, CTL_NORMAL); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    n_cmp++; if (a_ctl !== CTL_STALL) begin n_fail++; $display("FAIL lu_stall got %b want %b", a_ctl, CTL_STALL); end
    step();
    ex_reg_wren = 1'b0; ex_is_load = 1'b0;
    #1;
    n_cmp++; if (a_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL lu_release got %b want %b", a_ctl, CTL_NORMAL); end
    n_cmp++; if (a_stall !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", a_stall); end
    step();
    n_cmp++; if (a_stall !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt2 got %0d want 1", a_stall); end
  endtask

  task automatic test_no_stall();
    do_reset();
    set_load_use();
    ex_rd_address = 5'd0; id_rs2_address = 5'd0;
    #1;
    n_cmp++; if (a_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL ns_rd0 got %b want %b", a_ctl, CTL_NORMAL); end
    ex_rd_address = 5'd5; id_rs2_address = 5'd5; id_uses_rs2 = 1'b0;
    #1;
    n_cmp++; if (a_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL ns_unused got %b want %b", a_ctl, CTL_NORMAL); end
    id_uses_rs2 = 1'b1; ex_is_load = 1'b0;
    #1;
    n_cmp++; if (a_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL ns_noload got %b want %b", a_ctl, CTL_NORMAL); end
    ex_is_load = 1'b1; id_uses_rs2 = 1'b0; id_rs1_address = 5'd5;
    #1;
    n_cmp++; if (a_ctl !== CTL_STALL) begin n_fail++; $display("FAIL ns_rs1_hit got %b want %b", a_ctl, CTL_STALL); end
    set_idle();
    step();
    n_cmp++; if (a_stall !== 32'd0) begin n_fail++; $display("FAIL ns_stall_cnt got %0d want 0", a_stall); end
  endtask

  task automatic test_branch_override();
    do_reset();
    set_load_use();
    ex_branch_taken = 1'b1;
    #1;
    n_cmp++; if (a_ctl !== CTL_FLUSH) begin n_fail++; $display("FAIL br_ctl got %b want %b", a_ctl, CTL_FLUSH); end
    step();
    set_idle();
    #1;
    n_cmp++; if (a_flush !== 32'd1 || a_stall !== 32'd0) begin n_fail++; $display("FAIL br_cnt got %0d/%0d want 1/0", a_flush, a_stall); end
  endtask

  task automatic test_multicycle();
    do_reset();
    ex_mc_start = 1'b1;
    #1;
    n_cmp++; if (a_ctl !== CTL_HOLD) begin n_fail++; $display("FAIL mc_hold0 got %b want %b", a_ctl, CTL_HOLD); end
    step();
    ex_mc_start = 1'b0;
    set_load_use();
    ex_branch_taken = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      n_cmp++; if (a_ctl !== CTL_HOLD || a_state !== BUSY) begin n_fail++; $display("FAIL mc_hold%0d got %b/%0d want %b/1", i, a_ctl, a_state, CTL_HOLD); end
      step();
    end
    ex_mc_done = 1'b1;
    #1;
    n_cmp++; if (a_ctl !== CTL_FLUSH) begin n_fail++; $display("FAIL mc_release got %b want %b", a_ctl, CTL_FLUSH); end
    step();
    set_idle();
    #1;
    n_cmp++; if (a_stall !== 32'd5 || a_state !== IDLE || a_mc_timeout !== 1'b0) begin n_fail++; $display("FAIL mc_end got %0d/%0d/%b want 5/0/0", a_stall, a_state, a_mc_timeout); end
    // Start and done together is a one-cycle op: no hold.
    ex_mc_start = 1'b1; ex_mc_done = 1'b1;
    #1;
    n_cmp++; if (a_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL mc_1cyc got %b want %b", a_ctl, CTL_NORMAL); end
    step();
    set_idle();
    n_cmp++; if (a_state !== IDLE || a_stall !== 32'd5) begin n_fail++; $display("FAIL mc_1cyc_state got %0d/%0d want 0/5", a_state, a_stall); end
  endtask

  task automatic test_timeout();
    do_reset();
    ex_mc_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (b_ctl !== CTL_HOLD) begin n_fail++; $display("FAIL to_hold%0d got %b want %b", i, b_ctl, CTL_HOLD); end
      step();
      ex_mc_start = 1'b0;
    end
    #1;
    n_cmp++; if (b_state !== IDLE || b_mc_timeout !== 1'b1 || b_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL to_end got %0d/%b/%b want 0/1/%b", b_state, b_mc_timeout, b_ctl, CTL_NORMAL); end
    n_cmp++; if (b_stall !== 4'd4) begin n_fail++; $display("FAIL to_stall got %0d want 4", b_stall); end
    n_cmp++; if (a_mc_timeout !== 1'b0) begin n_fail++; $display("FAIL to_a_flag got %b want 0", a_mc_timeout); end
    repeat (3) step();
    n_cmp++; if (b_mc_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", b_mc_timeout); end
    do_reset();
    n_cmp++; if (b_mc_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b want 0", b_mc_timeout); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    repeat (19) step();
    n_cmp++; if (b_stall !== 4'hF) begin n_fail++; $display("FAIL sat_b got %h want f", b_stall); end
    n_cmp++; if (a_stall !== 32'd19) begin n_fail++; $display("FAIL sat_a got %0d want 19", a_stall); end
    set_idle();
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    ex_mc_start = 1'b1;
    step();
    ex_mc_start = 1'b0;
    step();
    n_cmp++; if (a_state !== BUSY || b_state !== BUSY) begin n_fail++; $display("FAIL sat_busy got %0d/%0d want 1/1", a_state, b_state); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_cmp++; if (a_state !== IDLE || b_state !== IDLE) begin n_fail++; $display("FAIL rst_busy_state got %0d/%0d want 0/0", a_state, b_state); end
    n_cmp++; if (a_stall !== 32'd0 || a_flush !== 32'd0 || b_stall !== 4'd0 || b_flush !== 4'd0) begin n_fail++; $display("FAIL rst_busy_cnt got %0d/%0d/%0d/%0d want 0/0/0/0", a_stall, a_flush, b_stall, b_flush); end
    #1;
    n_cmp++; if (a_ctl !== CTL_NORMAL) begin n_fail++; $display("FAIL rst_busy_ctl got %b want %b", a_ctl, CTL_NORMAL); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    set_idle();
    step();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_override();
    test_multicycle();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
